vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 44 ++++
 rtl/vram_arbiter.sv | 143 ++++++++++++++
 tb/tb_vram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vram_arbiter_if : video / CPU / VRAM signal bundle for the arbiter  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              vid_start;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_valid;
  logic              vid_busy;
  logic              vid_done;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_start, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_rdata, vid_valid, vid_busy, vid_done, cpu_ack, cpu_rdata, cpu_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_start, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_rdata, vid_valid, vid_busy, vid_done, cpu_ack, cpu_rdata, cpu_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vram_arbiter : single-port VRAM arbiter, video bursts vs CPU access |
// | Optional CPU anti-starvation: define VRAM_ARB_STARVE_EN            |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module vram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 8,
  parameter int MAX_WAIT  = 4
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  vram_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    VBURST = 1'b1
  } state_t;

  localparam logic [7:0]        LAST_IDX = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  generate
    if (BURST_LEN < 2 || BURST_LEN > 255 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_params
      $error("vram_arbiter: BURST_LEN or MAX_WAIT out of range");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              rd_q, rd_d;
  logic              tag_q, tag_d;
  logic              last_q, last_d;
  logic              ack_q, ack_d;

  logic              starve;
  logic              cpu_grant;
  logic              vid_rd;

  // Grant is gated by reset_n so nothing reaches the memory while reset is held.
  assign cpu_grant = reset_n && bus.cpu_req && !ack_q && ((state_q == IDLE) || starve);
  assign vid_rd    = (state_q == VBURST) && !pend_q && !bus.vid_start && !cpu_grant;

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
  logic [3:0] wait_q, wait_d;

  assign starve = (wait_q == WAIT_LIM);

  always_comb begin
    wait_d = 4'd0;
    if ((state_q == VBURST) && bus.cpu_req && !cpu_grant) begin
      wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    pend_d        = bus.vid_start;
    rd_d          = (cpu_grant && !bus.cpu_we) || vid_rd;
    tag_d         = vid_rd;
    last_d        = vid_rd && (cnt_q == LAST_IDX);
    ack_d         = cpu_grant;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    if (cpu_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (vid_rd) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = ptr_q;
      ptr_d        = ptr_q + PTR_ONE;
      cnt_d        = cnt_q + 8'd1;
      if (cnt_q == LAST_IDX) begin
        state_d = IDLE;
      end
    end

    // A new start always wins, including an abort of a running burst.
    if (bus.vid_start) begin
      state_d = VBURST;
      ptr_d   = bus.vid_addr;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
      tag_q   <= 1'b0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  // Returned data is steered by the registered tag, never by the current state.
  assign bus.vid_valid  = rd_q && tag_q;
  assign bus.vid_done   = rd_q && tag_q && last_q;
  assign bus.vid_rdata  = (rd_q && tag_q) ? bus.mem_rdata : '0;
  assign bus.cpu_rvalid = rd_q && !tag_q;
  assign bus.cpu_rdata  = (rd_q && !tag_q) ? bus.mem_rdata : '0;
  assign bus.vid_busy   = (state_q == VBURST);
  assign bus.cpu_ack    = cpu_grant;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vram_arbiter : directed + random bench with behavioural model    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_vram_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 8;
  localparam int MAX_WAIT  = 4;
`ifdef VRAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] vram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram[i]    = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
  end

  // Synchronous single-port VRAM
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= vram[bus.mem_addr];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active, m_pend, m_ackprev;
  bit         r_v, r_vid, r_last;
  logic [7:0] r_data;
  int         m_ptr, m_issued, m_wait;

  always @(negedge clk) begin : p_model
    bit          g, vr, ev;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    if (!reset_n) begin
      m_active = 0; m_pend = 0; m_ackprev = 0; r_v = 0; r_vid = 0; r_last = 0;
      r_data = 0; m_ptr = 0; m_issued = 0; m_wait = 0;
      chk("reset_ctrl", {bus.vid_valid, bus.vid_done, bus.vid_busy, bus.cpu_ack,
                         bus.cpu_rvalid, bus.mem_en, bus.mem_we}, 0);
      chk("reset_data", {bus.mem_addr, bus.mem_wdata, bus.vid_rdata, bus.cpu_rdata}, 0);
    end else begin
      g  = bus.cpu_req && !m_ackprev && (!m_active || (STARVE && m_wait == MAX_WAIT));
      vr = m_active && !m_pend && !bus.vid_start && !g;
      e_addr = g ? bus.cpu_addr : (vr ? 16'(m_ptr) : 16'h0);
      e_wd   = g ? bus.cpu_wdata : 8'h0;
      ev     = r_v && r_vid;
      chk("mem_ctrl", {bus.mem_en, bus.mem_we}, {(g || vr), (g && bus.cpu_we)});
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("cpu_ack", bus.cpu_ack, g);
      chk("vid_busy", bus.vid_busy, m_active);
      chk("vid_valid_done", {bus.vid_valid, bus.vid_done}, {ev, ev && r_last});
      chk("vid_rdata", bus.vid_rdata, ev ? r_data : 8'h0);
      chk("cpu_rvalid", bus.cpu_rvalid, r_v && !r_vid);
      chk("cpu_rdata", bus.cpu_rdata, (r_v && !r_vid) ? r_data : 8'h0);

      r_v = 0; r_vid = 0; r_last = 0;
      if (g && !bus.cpu_we) begin
        r_v = 1; r_data = ref_mem[bus.cpu_addr];
      end else if (vr) begin
        r_v = 1; r_vid = 1; r_last = (m_issued == BURST_LEN - 1);
        r_data = ref_mem[m_ptr];
      end
      if (g && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (vr) begin
        if (m_issued == BURST_LEN - 1) m_active = 0;
        m_ptr = (m_ptr + 1) & 16'hFFFF;
        m_issued++;
      end
      m_wait = (STARVE && m_active && bus.cpu_req && !g) ?
               ((m_wait == MAX_WAIT) ? m_wait : m_wait + 1) : 0;
      m_pend = bus.vid_start;
      if (bus.vid_start) begin
        m_active = 1; m_ptr = int'(bus.vid_addr); m_issued = 0;
      end
      m_ackprev = g;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.vid_start = 0; bus.vid_addr = 0; bus.cpu_req = 0;
    bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.vid_busy && n < 40) begin next(); n++; end
    chk("drain_busy", bus.vid_busy, 0);
    next(); next();
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 16'hFFF8 + 16'($urandom_range(0, 7));
    return 16'($urandom_range(0, 31));
  endfunction

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    logic [15:0] q_addr[$];
    logic [15:0] exp27 [8];
    int nval, ndone, t, ack_t, done_t, busy_at_done;
    logic [16:0] resume;
    bit ack_last;

    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    next();

    // Idle CPU write
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'hA5;
    @(negedge clk);
    chk("w_ctrl", {bus.mem_en, bus.mem_we, bus.cpu_ack}, 3'b111);
    chk("w_addr", bus.mem_addr, 16'h1234);
    chk("w_data", bus.mem_wdata, 8'hA5);
    next(); idle_inputs();
    @(negedge clk);
    chk("w_no_rvalid", bus.cpu_rvalid, 0);
    next();

    // Wrapping burst from 0xFFFE
    exp27 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    bus.vid_start = 1; bus.vid_addr = 16'hFFFE;
    next(); idle_inputs();
    nval = 0; ndone = 0; busy_at_done = 1;
    q_addr.delete();
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_en) q_addr.push_back(bus.mem_addr);
      if (bus.vid_valid) nval++;
      if (bus.vid_done) begin ndone++; busy_at_done = int'(bus.vid_busy); end
      next();
    end
    chk("b_nreads", q_addr.size(), 8);
    for (int i = 0; i < 8; i++) chk("b_addr", (i < q_addr.size()) ? q_addr[i] : 16'hDEAD, exp27[i]);
    chk("b_nvalid", nval, 8);
    chk("b_ndone", ndone, 1);
    chk("b_busy_at_done", busy_at_done, 0);
    drain();

    // Simultaneous CPU read and video start in IDLE
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
    bus.vid_start = 1; bus.vid_addr = 16'h0100;
    @(negedge clk);
    chk("s_ack", {bus.cpu_ack, bus.mem_en, bus.mem_we}, 3'b110);
    chk("s_cpu_addr", bus.mem_addr, 16'h0010);
    next(); idle_inputs();
    @(negedge clk);
    chk("s_rvalid", {bus.cpu_rvalid, bus.mem_en}, 2'b10);
    next();
    @(negedge clk);
    chk("s_first_vid", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 16'h0100});
    next();
    drain();

    // CPU request raised at burst word 1
    bus.vid_start = 1; bus.vid_addr = 16'h0100;
    next(); idle_inputs();
    next(); next();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0040;
    t = 3; ack_t = -1; done_t = -1; nval = 0; resume = 17'h1FFFF;
    repeat (14) begin
      @(negedge clk);
      if (ack_t >= 0 && t == ack_t + 1) resume = {bus.mem_en, bus.mem_addr};
      if (bus.cpu_ack && ack_t < 0) ack_t = t;
      if (bus.vid_valid) nval++;
      if (bus.vid_done) done_t = t;
      next();
      if (ack_t >= 0) bus.cpu_req = 0;
      t++;
    end
    chk("st_ack_t", ack_t, STARVE ? 7 : 10);
    chk("st_done_t", done_t, STARVE ? 11 : 10);
    chk("st_nvalid", nval, 8);
    chk("st_resume", resume, STARVE ? {1'b1, 16'h0105} : 17'h0);
    idle_inputs();
    drain();

    // Abort at word 3 and restart from 0x0200
    bus.vid_start = 1; bus.vid_addr = 16'h0100;
    next(); idle_inputs();
    next(); next(); next(); next();
    bus.vid_start = 1; bus.vid_addr = 16'h0200;
    t = 5; ndone = 0; done_t = -1;
    q_addr.delete();
    repeat (14) begin
      @(negedge clk);
      if (bus.mem_en && t >= 6) q_addr.push_back(bus.mem_addr);
      if (bus.vid_done) begin ndone++; done_t = t; end
      next();
      bus.vid_start = 0;
      t++;
    end
    chk("ab_ndone", ndone, 1);
    chk("ab_done_t", done_t, 15);
    chk("ab_nreads", q_addr.size(), 8);
    for (int i = 0; i < 8; i++) chk("ab_addr", (i < q_addr.size()) ? q_addr[i] : 16'hDEAD, 16'h0200 + 16'(i));
    drain();

    // Asynchronous reset at burst word 5
    bus.vid_start = 1; bus.vid_addr = 16'h0300;
    next(); idle_inputs();
    repeat (6) next();
    #2 reset_n = 0;
    #1;
    chk("ar_ctrl", {bus.vid_valid, bus.vid_done, bus.vid_busy, bus.cpu_ack,
                    bus.cpu_rvalid, bus.mem_en, bus.mem_we}, 0);
    chk("ar_data", {bus.mem_addr, bus.mem_wdata, bus.vid_rdata, bus.cpu_rdata}, 0);
    @(negedge clk);
    next();
    reset_n = 1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0050;
    @(negedge clk);
    chk("ar_first_ack", bus.cpu_ack, 1);
    next(); idle_inputs();
    nval = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.vid_valid || bus.vid_done) nval++;
      next();
    end
    chk("ar_no_video", nval, 0);

    // Randomised traffic, checked by the model every cycle
    ack_last = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.cpu_req && ack_last && $urandom_range(0, 1) == 0) bus.cpu_req = 0;
      if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
        bus.cpu_req   = 1;
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = pick_addr();
        bus.cpu_wdata = 8'($urandom);
      end
      bus.vid_start = ($urandom_range(0, 11) == 0);
      if (bus.vid_start) bus.vid_addr = pick_addr();
      @(negedge clk);
      ack_last = bus.cpu_ack;
      next();
    end
    idle_inputs();
    repeat (3) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
